// File: rtl/data_stack_ctrl_if.sv
// Command handshake between the instruction sequencer and the data-stack controller.
interface data_stack_ctrl_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  cmd_valid;
  logic [1:0]            cmd_op;
  logic [DATA_WIDTH-1:0] cmd_data;
  logic                  cmd_ready;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/data_stack_ctrl.sv
// Forth data-stack controller: TOS/NOS cached in registers, deeper cells spilled to memory.
// Optional high-water-mark register enabled by defining DSTACK_HWM_EN.
module data_stack_ctrl #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 16,
  parameter int BASE_ADDR   = 0,
  parameter int STACK_DEPTH = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  data_stack_ctrl_if.slave      cmd,
  output logic [DATA_WIDTH-1:0] tos,
  output logic [DATA_WIDTH-1:0] nos,
  output logic [ADDR_WIDTH:0]   depth,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic [ADDR_WIDTH-1:0] mem_write_addr,
  output logic [ADDR_WIDTH-1:0] mem_read_addr,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH:0]   high_water
);

  typedef enum logic {IDLE, REFILL} state_t;

  localparam logic [1:0] OP_REPLACE     = 2'b00;
  localparam logic [1:0] OP_PUSH        = 2'b01;
  localparam logic [1:0] OP_POP         = 2'b10;
  localparam logic [1:0] OP_POP_REPLACE = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] BASE_L = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   SD_L   = (ADDR_WIDTH+1)'(STACK_DEPTH);
  localparam logic [ADDR_WIDTH:0]   ONE    = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH:0]   TWO    = (ADDR_WIDTH+1)'(2);

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   tos_reg, tos_next;
  logic [DATA_WIDTH-1:0]   nos_reg, nos_next;
  logic [ADDR_WIDTH:0]     depth_reg, depth_next;
  logic                    overflow_reg, overflow_next;
  logic                    underflow_reg, underflow_next;
  logic [ADDR_WIDTH:0]     sp;
  logic                    ready;

  // Spilled count: everything below the two cached cells.
  assign sp = (depth_reg >= TWO) ? (depth_reg - TWO) : '0;

  assign mem_write_addr = BASE_L + sp[ADDR_WIDTH-1:0];
  assign mem_read_addr  = BASE_L + sp[ADDR_WIDTH-1:0] - ADDR_WIDTH'(1);
  assign mem_data       = nos_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      tos_reg       <= '0;
      nos_reg       <= '0;
      depth_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      tos_reg       <= tos_next;
      nos_reg       <= nos_next;
      depth_reg     <= depth_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    tos_next       = tos_reg;
    nos_next       = nos_reg;
    depth_next     = depth_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    mem_we         = 1'b0;
    ready          = 1'b0;
    case (state_reg)
      IDLE: begin
        ready = 1'b1;
        if (cmd.cmd_valid) begin
          case (cmd.cmd_op)
            OP_REPLACE: begin
              if (depth_reg == '0) underflow_next = 1'b1;
              else                 tos_next       = cmd.cmd_data;
            end
            OP_PUSH: begin
              if (depth_reg >= TWO && sp == SD_L) begin
                overflow_next = 1'b1;
              end else begin
                tos_next   = cmd.cmd_data;
                nos_next   = tos_reg;
                depth_next = depth_reg + ONE;
                mem_we     = (depth_reg >= TWO);
              end
            end
            OP_POP: begin
              if (depth_reg == '0) begin
                underflow_next = 1'b1;
              end else begin
                tos_next   = nos_reg;
                depth_next = depth_reg - ONE;
                if (sp != '0) state_next = REFILL;
                else          nos_next   = '0;
              end
            end
            default: begin
              if (depth_reg < TWO) begin
                underflow_next = 1'b1;
              end else begin
                tos_next   = cmd.cmd_data;
                depth_next = depth_reg - ONE;
                if (sp != '0) state_next = REFILL;
                else          nos_next   = '0;
              end
            end
          endcase
        end
      end
      default: begin
        // mem_q holds ram[old sp-1], addressed during the accept cycle.
        nos_next   = mem_q;
        state_next = IDLE;
      end
    endcase
  end

  assign cmd.cmd_ready = ready;
  assign tos           = tos_reg;
  assign nos           = nos_reg;
  assign depth         = depth_reg;
  assign overflow      = overflow_reg;
  assign underflow     = underflow_reg;

`ifdef DSTACK_HWM_EN
  logic [ADDR_WIDTH:0] high_water_reg;

  always_ff @(posedge clock) begin
    if (reset)                        high_water_reg <= '0;
    else if (depth_reg > high_water_reg) high_water_reg <= depth_reg;
  end

  assign high_water = high_water_reg;
`else
  assign high_water = '0;
`endif

endmodule

// File: tb/tb_data_stack_ctrl.sv
// Scoreboard bench for data_stack_ctrl: a queue-based stack model predicts each command's outcome.
module tb_data_stack_ctrl;
  localparam int DW   = 16;
  localparam int AW   = 8;
  localparam int BASE = 8;
  localparam int SD   = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  data_stack_ctrl_if #(.DATA_WIDTH(DW)) cmd_if ();

  logic [DW-1:0] tos, nos, mem_data, mem_q;
  logic [AW:0]   depth, high_water;
  logic          overflow, underflow, mem_we;
  logic [AW-1:0] mem_write_addr, mem_read_addr;

  data_stack_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BASE_ADDR(BASE), .STACK_DEPTH(SD)
  ) dut (
    .clock(clock), .reset(reset), .cmd(cmd_if),
    .tos(tos), .nos(nos), .depth(depth), .overflow(overflow), .underflow(underflow),
    .mem_data(mem_data), .mem_write_addr(mem_write_addr), .mem_read_addr(mem_read_addr),
    .mem_we(mem_we), .mem_q(mem_q), .high_water(high_water)
  );

  // Dual-port memory with registered read
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (mem_we) ram[mem_write_addr] <= mem_data;
    mem_q <= ram[mem_read_addr];
  end

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic [DW-1:0] tos;
    logic [DW-1:0] nos;
    logic [AW:0]   depth;
    logic          uf;
    logic          of;
    int            busy;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] mdl[$];
  logic          m_uf, m_of;
  int            m_hw;

  function automatic void model_apply(input logic [1:0] op, input logic [DW-1:0] d,
                                      output logic spill, output int busy);
    int sz = mdl.size();
    spill = 1'b0;
    busy  = 0;
    case (op)
      2'b00: if (sz < 1) m_uf = 1'b1; else mdl[sz-1] = d;
      2'b01: if (sz >= SD + 2) m_of = 1'b1;
             else begin spill = (sz >= 2); mdl.push_back(d); end
      2'b10: if (sz < 1) m_uf = 1'b1;
             else begin void'(mdl.pop_back()); busy = (sz >= 3) ? 1 : 0; end
      default: if (sz < 2) m_uf = 1'b1;
               else begin void'(mdl.pop_back()); mdl[sz-2] = d; busy = (sz >= 3) ? 1 : 0; end
    endcase
    if (mdl.size() > m_hw) m_hw = mdl.size();
  endfunction

  function automatic logic [AW:0] hw_exp();
`ifdef DSTACK_HWM_EN
    return (AW+1)'(m_hw);
`else
    return '0;
`endif
  endfunction

  task automatic apply_reset();
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 2'b00;
    cmd_if.cmd_data  = '0;
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    mdl.delete();
    m_uf = 1'b0;
    m_of = 1'b0;
    m_hw = 0;
  endtask

  task automatic do_cmd(input string name, input logic [1:0] op, input logic [DW-1:0] d);
    exp_t e;
    logic spill;
    int   busy_exp, busy;
    model_apply(op, d, spill, busy_exp);
    e.name  = name;
    e.tos   = (mdl.size() >= 1) ? mdl[mdl.size()-1] : '0;
    e.nos   = (mdl.size() >= 2) ? mdl[mdl.size()-2] : '0;
    e.depth = (AW+1)'(mdl.size());
    e.uf    = m_uf;
    e.of    = m_of;
    e.busy  = busy_exp;
    sb.push_back(e);

    @(negedge clock);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = d;
    #1;
    checks++;
    if (cmd_if.cmd_ready !== 1'b1)
      $display("FAIL %s.ready_at_issue got=%b exp=1", name, cmd_if.cmd_ready);
    checks++;
    if (mem_we !== spill) begin
      failures++;
      $display("FAIL %s.mem_we got=%b exp=%b", name, mem_we, spill);
    end
    if (cmd_if.cmd_ready !== 1'b1) failures++;
    @(posedge clock);
    @(negedge clock);
    cmd_if.cmd_valid = 1'b0;
    busy = 0;
    while (cmd_if.cmd_ready !== 1'b1 && busy < 8) begin
      checks++;
      if (mem_we !== 1'b0) begin
        failures++;
        $display("FAIL %s.mem_we_in_refill got=%b exp=0", name, mem_we);
      end
      busy++;
      @(negedge clock);
    end

    e = sb.pop_front();
    $display("txn %s op=%0d data=%h tos=%h nos=%h depth=%0d uf=%b of=%b busy=%0d",
             e.name, op, d, tos, nos, depth, underflow, overflow, busy);
    checks++;
    if (tos !== e.tos) begin failures++; $display("FAIL %s.tos got=%h exp=%h", e.name, tos, e.tos); end
    checks++;
    if (nos !== e.nos) begin failures++; $display("FAIL %s.nos got=%h exp=%h", e.name, nos, e.nos); end
    checks++;
    if (depth !== e.depth) begin failures++; $display("FAIL %s.depth got=%0d exp=%0d", e.name, depth, e.depth); end
    checks++;
    if (underflow !== e.uf) begin failures++; $display("FAIL %s.underflow got=%b exp=%b", e.name, underflow, e.uf); end
    checks++;
    if (overflow !== e.of) begin failures++; $display("FAIL %s.overflow got=%b exp=%b", e.name, overflow, e.of); end
    checks++;
    if (busy !== e.busy) begin failures++; $display("FAIL %s.busy got=%0d exp=%0d", e.name, busy, e.busy); end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (tos !== '0 || nos !== '0) begin
      failures++; $display("FAIL reset.tos_nos got=%h/%h exp=0/0", tos, nos);
    end
    checks++;
    if (depth !== '0) begin failures++; $display("FAIL reset.depth got=%0d exp=0", depth); end
    checks++;
    if (underflow !== 1'b0 || overflow !== 1'b0) begin
      failures++; $display("FAIL reset.flags got=%b%b exp=00", underflow, overflow);
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || mem_we !== 1'b0) begin
      failures++; $display("FAIL reset.ready_we got=%b%b exp=10", cmd_if.cmd_ready, mem_we);
    end
    checks++;
    if (mem_write_addr !== AW'(BASE) || mem_read_addr !== AW'(BASE - 1)) begin
      failures++; $display("FAIL reset.addrs got=%h/%h exp=%h/%h", mem_write_addr, mem_read_addr,
                           AW'(BASE), AW'(BASE - 1));
    end
    checks++;
    if (high_water !== hw_exp()) begin
      failures++; $display("FAIL reset.high_water got=%0d exp=%0d", high_water, hw_exp());
    end
  endtask

  task automatic test_push();
    do_cmd("push1", 2'b01, 16'h1111);
    do_cmd("push2", 2'b01, 16'h2222);
    do_cmd("push3", 2'b01, 16'h3333);
    checks++;
    if (ram[BASE] !== 16'h1111) begin
      failures++; $display("FAIL push.ram_base got=%h exp=1111", ram[BASE]);
    end
    checks++;
    if (mem_write_addr !== AW'(BASE + 1)) begin
      failures++; $display("FAIL push.write_addr got=%h exp=%h", mem_write_addr, AW'(BASE + 1));
    end
  endtask

  task automatic test_pop_refill();
    do_cmd("pop_refill", 2'b10, 16'h0000);
    checks++;
    if (mem_write_addr !== AW'(BASE)) begin
      failures++; $display("FAIL pop_refill.sp_zero got=%h exp=%h", mem_write_addr, AW'(BASE));
    end
  endtask

  task automatic test_underflow();
    apply_reset();
    do_cmd("uf_pop_empty", 2'b10, 16'h0000);
    do_cmd("uf_replace_empty", 2'b00, 16'h7777);
    do_cmd("uf_push5", 2'b01, 16'h0005);
    do_cmd("uf_popreplace_d1", 2'b11, 16'h9999);
    do_cmd("uf_replace_d1", 2'b00, 16'h0006);
  endtask

  task automatic test_overflow();
    apply_reset();
    for (int i = 0; i < 7; i++) do_cmd($sformatf("of_push%0d", i), 2'b01, DW'(16'h0100 + i));
    for (int i = 0; i < SD; i++) begin
      checks++;
      if (ram[BASE + i] !== DW'(16'h0100 + i)) begin
        failures++; $display("FAIL overflow.ram%0d got=%h exp=%h", i, ram[BASE + i], DW'(16'h0100 + i));
      end
    end
    @(negedge clock);
    checks++;
    if (high_water !== hw_exp()) begin
      failures++; $display("FAIL overflow.high_water got=%0d exp=%0d", high_water, hw_exp());
    end
  endtask

  task automatic test_pop_replace();
    apply_reset();
    do_cmd("pr_push_a", 2'b01, 16'hA001);
    do_cmd("pr_push_b", 2'b01, 16'hA002);
    do_cmd("pr_push_c", 2'b01, 16'hA003);
    do_cmd("pr_push_d", 2'b01, 16'hA004);
    do_cmd("pr_aaaa", 2'b11, 16'hAAAA);
    do_cmd("pr_replace", 2'b00, 16'h1234);
    do_cmd("pr_pop_d3", 2'b10, 16'h0000);
    do_cmd("pr_pop_d2", 2'b10, 16'h0000);
    do_cmd("pr_popreplace_d1", 2'b11, 16'hBBBB);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 50; i++) begin
      logic [1:0] op;
      op = (i < 6) ? 2'b01 : 2'($urandom_range(0, 3));
      do_cmd($sformatf("rnd%0d", i), op, DW'($urandom));
    end
  endtask

  task automatic test_reset_in_refill();
    int n;
    apply_reset();
    do_cmd("rr_push1", 2'b01, 16'hC001);
    do_cmd("rr_push2", 2'b01, 16'hC002);
    do_cmd("rr_push3", 2'b01, 16'hC003);
    @(negedge clock);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 2'b10;
    n = 0;
    while (cmd_if.cmd_ready !== 1'b1 && n < 8) begin n++; @(negedge clock); end
    @(posedge clock);
    @(negedge clock);
    cmd_if.cmd_valid = 1'b0;
    checks++;
    if (cmd_if.cmd_ready !== 1'b0) begin
      failures++; $display("FAIL rr.in_refill got=%b exp=0", cmd_if.cmd_ready);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    mdl.delete();
    m_uf = 1'b0;
    m_of = 1'b0;
    m_hw = 0;
    $display("txn rr_reset tos=%h nos=%h depth=%0d ready=%b hw=%0d", tos, nos, depth,
             cmd_if.cmd_ready, high_water);
    checks++;
    if (tos !== '0 || nos !== '0 || depth !== '0) begin
      failures++; $display("FAIL rr.state got=%h/%h/%0d exp=0/0/0", tos, nos, depth);
    end
    checks++;
    if (cmd_if.cmd_ready !== 1'b1 || mem_we !== 1'b0) begin
      failures++; $display("FAIL rr.ready_we got=%b%b exp=10", cmd_if.cmd_ready, mem_we);
    end
    checks++;
    if (high_water !== '0) begin
      failures++; $display("FAIL rr.high_water got=%0d exp=0", high_water);
    end
    do_cmd("rr_push_after", 2'b01, 16'hD00D);
  endtask

  initial begin
    test_reset();
    test_push();
    test_pop_refill();
    test_underflow();
    test_overflow();
    test_pop_replace();
    test_back_to_back();
    test_reset_in_refill();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
